// File: rtl/prio_scan_encoder.sv
`default_nettype none
// ============================================================================
// Module      : prio_scan_encoder
// Description : Registered priority scan encoder. Accepts a WIDTH-bit request
//               vector over valid/ready and emits the index of every set bit,
//               one beat per index, highest index first. An all-zero vector
//               produces a single beat flagged with out_none.
//               Optional feature macro: PRIO_SCAN_COUNT_EN (adds out_cnt,
//               the population count of the accepted vector).
// Revision    : 1.0 - initial release
// ============================================================================
module prio_scan_encoder #(
  parameter int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none,
  output logic             busy
`ifdef PRIO_SCAN_COUNT_EN
  ,
  output logic [IDX_W:0]   out_cnt
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] pending, pending_d;
  logic [IDX_W-1:0] idx_d;
  logic             last_d, none_d, valid_d;

  // Highest set bit of a vector; zero when no bit is set.
  function automatic logic [IDX_W-1:0] hi_index(input logic [WIDTH-1:0] v);
    hi_index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) hi_index = IDX_W'(i);
    end
  endfunction

  // Vector with the selected bit removed.
  function automatic logic [WIDTH-1:0] clr_bit(input logic [WIDTH-1:0] v,
                                               input logic [IDX_W-1:0] b);
    clr_bit = v & ~(WIDTH'(1) << b);
  endfunction

  logic             accept;
  logic             beat_done;
  logic [IDX_W-1:0] in_hi, pend_hi;
  logic [WIDTH-1:0] in_rest, pend_rest;

  assign busy      = (state == SCAN);
  assign in_ready  = en & ~busy;
  assign accept    = in_valid & in_ready;
  assign beat_done = out_valid & out_ready;
  assign in_hi     = hi_index(in_vec);
  assign in_rest   = clr_bit(in_vec, in_hi);
  assign pend_hi   = hi_index(pending);
  assign pend_rest = clr_bit(pending, pend_hi);

`ifdef PRIO_SCAN_COUNT_EN
  logic [IDX_W:0] cnt_d;

  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    popcount = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) popcount = popcount + 1'b1;
    end
  endfunction

  // Count is captured on accept and held for the whole scan.
  always_comb begin
    cnt_d = out_cnt;
    if (state == IDLE && accept) cnt_d = popcount(in_vec);
  end

  // Population-count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_cnt <= '0;
    else     out_cnt <= cnt_d;
  end
`else
  // Population count feature absent in this build.
`endif

  // Next-state and next-output logic; everything holds unless a transfer
  // or an output handshake happens.
  always_comb begin
    state_d   = state;
    pending_d = pending;
    idx_d     = out_idx;
    last_d    = out_last;
    none_d    = out_none;
    valid_d   = out_valid;
    case (state)
      IDLE: begin
        if (accept) begin
          valid_d = 1'b1;
          state_d = SCAN;
          if (in_vec == '0) begin
            idx_d     = '0;
            pending_d = '0;
            last_d    = 1'b1;
            none_d    = 1'b1;
          end else begin
            idx_d     = in_hi;
            pending_d = in_rest;
            last_d    = (in_rest == '0);
            none_d    = 1'b0;
          end
        end
      end
      SCAN: begin
        if (beat_done) begin
          if (out_last) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            none_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d     = pend_hi;
            pending_d = pend_rest;
            last_d    = (pend_rest == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pending-bit and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_none  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      pending   <= pending_d;
      out_idx   <= idx_d;
      out_last  <= last_d;
      out_none  <= none_d;
      out_valid <= valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prio_scan_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_prio_scan_encoder
// Description : Self-checking bench for prio_scan_encoder. Expected beats come
//               from a queue of set-bit indices built from the input vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prio_scan_encoder;

  localparam int W  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_vec = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_none;
  logic          busy;
`ifdef PRIO_SCAN_COUNT_EN
  logic [IW:0]   out_cnt;
`endif

  int errors = 0;
  int checks = 0;

  prio_scan_encoder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_last(out_last), .out_none(out_none), .busy(busy)
`ifdef PRIO_SCAN_COUNT_EN
    , .out_cnt(out_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_idx !== '0 ||
        out_last !== 1'b0 || out_none !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b busy=%b idx=%0d last=%b none=%b, required 0 0 0 0 0",
               out_valid, busy, out_idx, out_last, out_none);
    end
`ifdef PRIO_SCAN_COUNT_EN
    checks++;
    if (out_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d required 0", out_cnt);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  // Send one vector and check every beat against the reference list.
  // ready_pct: probability (percent) that out_ready is high on a cycle.
  // en_scan: value of en while the scan runs.
  task automatic run_vec(input logic [W-1:0] vec, input int ready_pct,
                         input logic en_scan);
    int  q[$];
    int  pc;
    int  cycles;
    bit  zero;
    pc = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        q.push_back(i);
        pc++;
      end
    end
    zero = (q.size() == 0);
    if (zero) q.push_back(0);

    en = 1'b1; in_vec = vec; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready vec=%h: in_ready=%b required 1", vec, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    en = en_scan;

    cycles = 0;
    while (q.size() > 0 && cycles < 500) begin
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 ||
          out_idx !== IW'(q[0]) || out_last !== (q.size() == 1) ||
          out_none !== zero) begin
        errors++;
        $display("FAIL beat vec=%h: valid=%b busy=%b rdy=%b idx=%0d last=%b none=%b, required 1 1 0 %0d %b %b",
                 vec, out_valid, busy, in_ready, out_idx, out_last, out_none,
                 q[0], (q.size() == 1), zero);
      end
`ifdef PRIO_SCAN_COUNT_EN
      checks++;
      if (out_cnt !== (IW + 1)'(pc)) begin
        errors++;
        $display("FAIL beat_cnt vec=%h: got %0d required %0d", vec, out_cnt, pc);
      end
`endif
      out_ready = ($urandom_range(99) < ready_pct);
      in_valid  = $urandom_range(1);
      in_vec    = W'($urandom);
      @(negedge clk);
      if (out_ready) void'(q.pop_front());
      cycles++;
    end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL beat_budget vec=%h: %0d beats outstanding, required 0", vec, q.size());
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== en_scan) begin
      errors++;
      $display("FAIL scan_end vec=%h: valid=%b busy=%b rdy=%b, required 0 0 %b",
               vec, out_valid, busy, in_ready, en_scan);
    end
    en = 1'b1;
  endtask

  task automatic test_multi_bit();
    run_vec(8'b1010_0110, 100, 1'b1);
  endtask

  task automatic test_zero();
    run_vec(8'h00, 100, 1'b1);
  endtask

  task automatic test_backpressure();
    en = 1'b1; in_vec = 8'h90; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 3'd7 || out_last !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d: valid=%b idx=%0d last=%b, required 1 7 0",
                 c, out_valid, out_idx, out_last);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd7 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: valid=%b idx=%0d last=%b, required 1 7 0",
               out_valid, out_idx, out_last);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd4 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL stall_second: valid=%b idx=%0d last=%b, required 1 4 1",
               out_valid, out_idx, out_last);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_extra: valid=%b busy=%b, required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_enable();
    en = 1'b0; in_valid = 1'b1; in_vec = 8'h55;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL en_low: rdy=%b busy=%b valid=%b, required 0 0 0",
                 in_ready, busy, out_valid);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    run_vec(8'h03, 100, 1'b0);
  endtask

  task automatic test_reset_mid_scan();
    en = 1'b1; in_vec = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== IW'(7 - b)) begin
        errors++;
        $display("FAIL pre_reset_beat %0d: valid=%b idx=%0d, required 1 %0d",
                 b, out_valid, out_idx, 7 - b);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_idx !== '0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b busy=%b idx=%0d last=%b, required 0 0 0 0",
               out_valid, busy, out_idx, out_last);
    end
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(8'h01, 100, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] v;
      v = W'($urandom);
      if (n % 10 == 3) v = '0;
      run_vec(v, 40 + $urandom_range(60), 1'b1);
    end
  endtask

  // Each vector is offered the same cycle in_ready returns.
  task automatic test_back_to_back();
    for (int n = 0; n < 5; n++) run_vec(W'($urandom), 100, 1'b1);
  endtask

  initial begin
    test_reset();
    test_multi_bit();
    test_zero();
    test_backpressure();
    test_enable();
    test_reset_mid_scan();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prio_scan_encoder.md
# prio_scan_encoder

Parametrised, registered priority scan encoder. Accepts a WIDTH-bit request vector over a valid/ready handshake and emits the index of every set bit, one per output beat, highest index first. It generalises the 8-to-3 enable-gated priority encoder from a single combinational highest-bit lookup to a sequential scan of all set bits. It is the request-decode front end for interrupt and arbitration logic in the datapath.

## Interface
- WIDTH, 8, request vector width; WIDTH >= 2, need not be a power of two
- IDX_W, $clog2(WIDTH), derived index width; never overridden
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, asynchronous and active-high
- en  input  1  enable; gates input acceptance only
- in_valid  input  1  in_vec is valid
- in_ready  output  1  block can accept a vector; combinational, en & ~busy
- in_vec  input  WIDTH  request vector
- out_valid  output  1  out_idx/out_last/out_none valid
- out_ready  input  1  downstream accepts the current beat
- out_idx  output  IDX_W  index of the current set bit
- out_last  output  1  final beat of the current vector
- out_none  output  1  accepted vector was all-zero
- busy  output  1  scan in progress (state SCAN)
- out_cnt  output  IDX_W+1  population count of accepted vector; present only with PRIO_SCAN_COUNT_EN

## Operation
- States: IDLE, SCAN.
- Reset, asynchronous: state IDLE. Pending register 0. out_valid, out_last, out_none, busy all 0. out_idx 0. out_cnt 0.
- IDLE: in_ready = en. A transfer occurs when in_valid & in_ready.
- Non-zero vector on transfer:
  - out_idx <= highest set bit.
  - pending <= in_vec with that bit cleared.
  - out_last <= (pending == 0), out_none <= 0, out_valid <= 1, state SCAN.
- Zero vector on transfer: exactly one beat with out_idx = 0, out_none = 1, out_last = 1, then state SCAN.
- SCAN, on out_valid & out_ready:
  - If out_last: out_valid <= 0, out_last <= 0, out_none <= 0, state IDLE.
  - Otherwise: out_idx <= highest set bit of pending, clear that bit, out_last <= (remaining == 0).
- Backpressure: while out_ready = 0, all outputs and pending hold. No index is skipped or repeated.
- en deasserted during SCAN: the scan runs to completion. en affects only in_ready.
- in_valid in SCAN is ignored (in_ready = 0).
- Bits at or above WIDTH do not exist. out_idx never exceeds WIDTH-1.

## Timing
- Latency: vector accepted at edge N; first beat visible on out_valid after edge N (cycle N+1).
- With out_ready held high, a vector with K set bits produces K beats on consecutive cycles.
- Zero vector produces 1 beat.
- Last handshake at edge M: state returns to IDLE and in_ready is high in cycle M+1 (if en). Earliest next accept is edge M+1.
- Peak throughput: one vector per K+1 cycles.
- Reset mid-scan: outputs drop to reset values immediately. The in-flight vector is discarded.

## Configuration
- PRIO_SCAN_COUNT_EN defined:
  - out_cnt port exists.
  - Loaded with popcount(in_vec) on transfer (0 for a zero vector).
  - Held stable for the whole scan; reset value 0.
- Not defined: out_cnt port and popcount logic are absent. All other behaviour is identical.

## Test plan
- Reset: assert rst, en = 1 -> out_valid = 0, busy = 0, out_idx = 0, in_ready = 1 after release.
- WIDTH = 8, in_vec = 8'b1010_0110, out_ready = 1 -> beats out_idx = 7, 5, 2, 1 on consecutive cycles; out_last only on 1; in_ready high the cycle after; out_cnt = 4 with macro.
- in_vec = 8'h00 -> single beat with out_idx = 0, out_none = 1, out_last = 1; out_cnt = 0.
- in_vec = 8'h90, out_ready low for 3 cycles after first beat -> out_idx = 7 held for 3 cycles, then 4 with out_last; no extra beats.
- en = 0 with in_valid = 1 -> no accept, busy = 0. Drop en mid-scan of 8'h03 -> beats 1, 0 still complete.
- Scan 8'hFF, assert rst after 3 beats -> out_valid = 0 immediately. After release, in_vec = 8'h01 -> one beat with out_idx = 0, out_none = 0, out_last = 1.
